// File: rtl/pu_riscv_bp_if.sv
// Branch predictor port bundle: IF read address/prediction, branch-unit update strobe.
// BP_GLOBAL_BITS and XLEN must match the pu_riscv_bp instance that uses it.
interface pu_riscv_bp_if #(
  parameter int XLEN           = 64,
  parameter int BP_GLOBAL_BITS = 2
);
  logic                      if_stall;
  logic [XLEN-1:0]           if_parcel_pc;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
  logic [XLEN-1:0]           ex_pc;
  logic                      bu_bp_update;
  logic                      bu_bp_btaken;
  logic [1:0]                bu_bp_predict;
  logic [1:0]                bp_bp_predict;
  logic                      bp_init_busy;

  modport master (
    output if_stall, if_parcel_pc, bu_bp_history, ex_pc,
           bu_bp_update, bu_bp_btaken, bu_bp_predict,
    input  bp_bp_predict, bp_init_busy
  );

  modport slave (
    input  if_stall, if_parcel_pc, bu_bp_history, ex_pc,
           bu_bp_update, bu_bp_btaken, bu_bp_predict,
    output bp_bp_predict, bp_init_busy
  );
endinterface

// File: rtl/pu_riscv_bp.sv
// Gshare BHT of 2-bit counters; prediction registered one cycle after the fetch PC.
// if_stall freezes the prediction register only; updates always land; table self-clears after reset.
module pu_riscv_bp #(
  parameter int XLEN           = 64,
  parameter int HAS_BPU        = 1,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10
) (
  input logic          clk,
  input logic          rst,
  pu_riscv_bp_if.slave bp
);
  logic [1:0] predict_q;
  logic       busy_q;

  assign bp.bp_bp_predict = predict_q;
  assign bp.bp_init_busy  = busy_q;

  if (HAS_BPU != 0) begin : g_bpu
    localparam int IW    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic {INIT, RUN} state_t;

    state_t        state;
    logic [IW-1:0] init_idx;
    logic [1:0]    table_q [DEPTH];
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] ram_addr;
    logic [1:0]    ram_dat;
    logic          ram_we;
    logic [1:0]    next_cnt;

    assign rd_idx = {bp.bu_bp_history, bp.if_parcel_pc[BP_LOCAL_BITS+1:2]};
    assign wr_idx = {bp.bu_bp_history, bp.ex_pc[BP_LOCAL_BITS+1:2]};

    // Counter update works from the value the branch was predicted with, not a re-read.
    always_comb begin
      next_cnt = bp.bu_bp_predict;
      if (bp.bu_bp_btaken) begin
        if (bp.bu_bp_predict != 2'b11) next_cnt = bp.bu_bp_predict + 2'd1;
      end else begin
        if (bp.bu_bp_predict != 2'b00) next_cnt = bp.bu_bp_predict - 2'd1;
      end
    end

    assign ram_we   = !rst && (state == INIT || bp.bu_bp_update);
    assign ram_addr = (state == INIT) ? init_idx : wr_idx;
    assign ram_dat  = (state == INIT) ? 2'b01 : next_cnt;

    always_ff @(posedge clk) begin
      if (ram_we) table_q[ram_addr] <= ram_dat;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= INIT;
        init_idx  <= '0;
        busy_q    <= 1'b1;
        predict_q <= 2'b00;
      end else begin
        case (state)
          INIT: begin
            predict_q <= 2'b00;
            init_idx  <= init_idx + IDX_ONE;
            if (&init_idx) begin
              state  <= RUN;
              busy_q <= 1'b0;
            end
          end
          RUN: begin
            // Same-cycle write to the entry being read wins (write-first).
            if (!bp.if_stall)
              predict_q <= (bp.bu_bp_update && rd_idx == wr_idx) ? next_cnt : table_q[rd_idx];
          end
        endcase
      end
    end

    a_update_known: assert property (@(posedge clk) disable iff (rst)
      (state == RUN && bp.bu_bp_update) |->
        !$isunknown({bp.ex_pc, bp.bu_bp_history, bp.bu_bp_btaken, bp.bu_bp_predict}));

  end else begin : g_no_bpu
    always_ff @(posedge clk) begin
      predict_q <= 2'b00;
      busy_q    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pu_riscv_bp.sv
// Bench for pu_riscv_bp (G=2, L=4): reference table model compared every cycle plus directed literal checks.
module tb_pu_riscv_bp;
  localparam int XLEN = 64;
  localparam int G    = 2;
  localparam int L    = 4;
  localparam int N    = 64;
  localparam logic [63:0] PC0 = 64'h8000_0000;

  logic clk;
  logic rst;

  pu_riscv_bp_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(G)) bpif ();

  pu_riscv_bp #(
    .XLEN(XLEN), .HAS_BPU(1), .BP_GLOBAL_BITS(G), .BP_LOCAL_BITS(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bpif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Reference: plain array of counters, remaining-init-cycle count, predicted value.
  int mtab [N];
  int mcnt  = 0;
  int mpred = 0;
  int mp;

  function automatic int idx_of(logic [63:0] pc, logic [1:0] h);
    return int'(h) * 16 + int'(pc[5:2]);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mcnt  = N;
      mpred = 0;
      foreach (mtab[i]) mtab[i] = 1;
    end else if (mcnt > 0) begin
      mcnt--;
      mpred = 0;
    end else begin
      if (bpif.bu_bp_update) begin
        mp = int'(bpif.bu_bp_predict);
        mtab[idx_of(bpif.ex_pc, bpif.bu_bp_history)] =
          bpif.bu_bp_btaken ? ((mp < 3) ? mp + 1 : 3) : ((mp > 0) ? mp - 1 : 0);
      end
      if (!bpif.if_stall) mpred = mtab[idx_of(bpif.if_parcel_pc, bpif.bu_bp_history)];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model_predict", 64'(bpif.bp_bp_predict), 64'(mpred));
      chk("model_busy", 64'(bpif.bp_init_busy), 64'(mcnt != 0));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    bpif.if_stall     = 1'b0;
    bpif.bu_bp_update = 1'b0;
  endtask

  task automatic set_rd(logic [63:0] pc, logic [1:0] h);
    bpif.if_parcel_pc  = pc;
    bpif.bu_bp_history = h;
  endtask

  task automatic set_wr(logic [63:0] pc, logic [1:0] p, logic t);
    bpif.bu_bp_update  = 1'b1;
    bpif.ex_pc         = pc;
    bpif.bu_bp_predict = p;
    bpif.bu_bp_btaken  = t;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (bpif.bp_init_busy === 1'b1 && c < 200) begin
      c++;
      cyc();
    end
  endtask

  logic [7:0] v_off  [4] = '{8'h3C, 8'h04, 8'h08, 8'h0C};
  logic [1:0] v_hist [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
  logic [1:0] v_pred [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
  logic       v_tkn  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] v_exp  [4] = '{2'b01, 2'b00, 2'b11, 2'b01};

  initial begin
    int c;
    rst = 1'b1;
    idle();
    set_rd(PC0, 2'd0);
    bpif.ex_pc         = PC0;
    bpif.bu_bp_predict = 2'b00;
    bpif.bu_bp_btaken  = 1'b0;
    cyc();
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_busy", 64'(bpif.bp_init_busy), 64'd1);
    chk("reset_predict", 64'(bpif.bp_bp_predict), 64'd0);
    chk("index_pin", 64'(idx_of(PC0 + 64'h10, 2'b10)), 64'd36);

    count_busy(c);
    chk("init_len", 64'(c), 64'd64);
    cyc();
    chk("read_after_init", 64'(bpif.bp_bp_predict), 64'd1);

    // Basic update of entry 36 then read-back
    set_rd(PC0, 2'b10);
    set_wr(PC0 + 64'h10, 2'b01, 1'b1);
    cyc();
    idle();
    set_rd(PC0 + 64'h10, 2'b10);
    cyc();
    chk("update_36", 64'(bpif.bp_bp_predict), 64'd2);

    // Saturation at both ends
    set_rd(PC0, 2'b10);
    set_wr(PC0 + 64'h10, 2'b11, 1'b1);
    cyc();
    idle();
    set_rd(PC0 + 64'h10, 2'b10);
    cyc();
    chk("sat_high", 64'(bpif.bp_bp_predict), 64'd3);
    set_rd(PC0, 2'b10);
    set_wr(PC0 + 64'h10, 2'b00, 1'b0);
    cyc();
    idle();
    set_rd(PC0 + 64'h10, 2'b10);
    cyc();
    chk("sat_low", 64'(bpif.bp_bp_predict), 64'd0);

    // Collision on entry 24: write-first
    set_rd(PC0 + 64'h20, 2'b01);
    set_wr(PC0 + 64'h20, 2'b01, 1'b1);
    cyc();
    idle();
    chk("collision", 64'(bpif.bp_bp_predict), 64'd2);
    cyc();
    chk("collision_stored", 64'(bpif.bp_bp_predict), 64'd2);

    // Stall holds output while the read entry is rewritten
    bpif.if_stall = 1'b1;
    set_wr(PC0 + 64'h20, 2'b10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold", 64'(bpif.bp_bp_predict), 64'd2);
    end
    idle();
    cyc();
    chk("stall_release", 64'(bpif.bp_bp_predict), 64'd3);

    // Assorted entries and directions
    for (int k = 0; k < 4; k++) begin
      set_rd(PC0, v_hist[k]);
      set_wr(PC0 + 64'(v_off[k]), v_pred[k], v_tkn[k]);
      cyc();
      idle();
      set_rd(PC0 + 64'(v_off[k]), v_hist[k]);
      cyc();
      chk("pattern", 64'(bpif.bp_bp_predict), 64'(v_exp[k]));
    end
    // Upper PC bits do not take part in the index
    set_rd(64'h0000_0001_0000_003C, 2'd3);
    cyc();
    chk("pc_alias", 64'(bpif.bp_bp_predict), 64'd1);

    // Reset in the middle of INIT, with updates held active throughout
    set_wr(PC0 + 64'h10, 2'b11, 1'b1);
    bpif.bu_bp_history = 2'b10;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midinit_busy", 64'(bpif.bp_init_busy), 64'd1);
    chk("midinit_predict", 64'(bpif.bp_bp_predict), 64'd0);
    count_busy(c);
    idle();
    chk("init_len_restart", 64'(c), 64'd64);
    for (int i = 0; i < N; i++) begin
      set_rd(PC0 + 64'(i % 16) * 64'd4, 2'(i / 16));
      cyc();
      chk("post_init_entry", 64'(bpif.bp_bp_predict), 64'd1);
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
